// File: rtl/subleq_sequencer.sv
// rtl/subleq_sequencer.sv - SUBLEQ core: fetch, operand read, write-back of mem[B]-mem[A], branch
module subleq_sequencer #(
   parameter int WORD_SIZE = 64,
   parameter int ADDR_W    = 16,
   parameter int START_PC  = 10
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic                 busy,
   output logic                 halted,
   output logic [ADDR_W-1:0]    pc,
   output logic [31:0]          instr_count,
   output logic [WORD_SIZE-1:0] add1,
   output logic [WORD_SIZE-1:0] dataIn1,
   output logic                 write1,
   input  logic [WORD_SIZE-1:0] dataOut1,
   output logic [WORD_SIZE-1:0] add2,
   output logic [WORD_SIZE-1:0] dataIn2,
   output logic                 write2,
   input  logic [WORD_SIZE-1:0] dataOut2
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_LATCH, S_READ, S_EXEC, S_HALT
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_W-1:0]     pc_q, pc_d;
   logic [3*ADDR_W-1:0]   ir_q, ir_d;
   logic [31:0]           instr_count_q, instr_count_d;

   logic [ADDR_W-1:0]     fld_a, fld_b, fld_c, npc;
   logic [WORD_SIZE-1:0]  diff;
   logic                  leq;

   // Only the three address fields are kept; bits above 3*ADDR_W carry no meaning.
   assign fld_a = ir_q[3*ADDR_W-1:2*ADDR_W];
   assign fld_b = ir_q[2*ADDR_W-1:ADDR_W];
   assign fld_c = ir_q[ADDR_W-1:0];

   assign diff = dataOut2 - dataOut1;
   assign leq  = diff[WORD_SIZE-1] | (diff == '0);
   assign npc  = leq ? fld_c : pc_q + ADDR_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         pc_q          <= '0;
         ir_q          <= '0;
         instr_count_q <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         ir_q          <= ir_d;
         instr_count_q <= instr_count_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      ir_d          = ir_q;
      instr_count_d = instr_count_q;
      add1          = '0;
      add2          = '0;
      dataIn2       = '0;
      write2        = 1'b0;
      case (state_q)
         S_IDLE, S_HALT: begin
            if (start) begin
               pc_d          = ADDR_W'(START_PC);
               instr_count_d = '0;
               state_d       = S_FETCH;
            end
         end
         S_FETCH: begin
            add1    = WORD_SIZE'(pc_q);
            state_d = S_LATCH;
         end
         S_LATCH: begin
            ir_d    = dataOut1[3*ADDR_W-1:0];
            state_d = S_READ;
         end
         S_READ: begin
            add1    = WORD_SIZE'(fld_a);
            add2    = WORD_SIZE'(fld_b);
            state_d = S_EXEC;
         end
         S_EXEC: begin
            add2          = WORD_SIZE'(fld_b);
            dataIn2       = diff;
            write2        = 1'b1;
            instr_count_d = instr_count_q + 32'd1;
            pc_d          = npc;
            // A taken branch onto itself can never make progress, so stop there.
            state_d       = (leq && (fld_c == pc_q)) ? S_HALT : S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy        = (state_q == S_FETCH) || (state_q == S_LATCH) ||
                        (state_q == S_READ)  || (state_q == S_EXEC);
   assign halted      = (state_q == S_HALT);
   assign pc          = pc_q;
   assign instr_count = instr_count_q;
   assign dataIn1     = '0;
   assign write1      = 1'b0;

endmodule

// File: tb/tb_subleq_sequencer.sv
// tb/tb_subleq_sequencer.sv - bench for subleq_sequencer with dual-port memory and ISA-level model
module tb_subleq_sequencer;

   localparam int WS  = 64;
   localparam int AW  = 16;
   localparam int SPC = 10;
   localparam int MD  = 64;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b1;
   logic          start = 1'b0;
   logic          busy, halted, write1, write2;
   logic [AW-1:0] pc;
   logic [31:0]   instr_count;
   logic [WS-1:0] add1, add2, dataIn1, dataIn2;
   logic [WS-1:0] dataOut1, dataOut2;

   logic [WS-1:0] mem [MD];
   logic          ld_en   = 1'b0;
   logic [5:0]    ld_addr = '0;
   logic [WS-1:0] ld_data = '0;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   subleq_sequencer #(.WORD_SIZE(WS), .ADDR_W(AW), .START_PC(SPC)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .halted(halted),
      .pc(pc), .instr_count(instr_count),
      .add1(add1), .dataIn1(dataIn1), .write1(write1), .dataOut1(dataOut1),
      .add2(add2), .dataIn2(dataIn2), .write2(write2), .dataOut2(dataOut2)
   );

   always @(posedge clk) begin
      if (ld_en) mem[ld_addr] <= ld_data;
      else if (write2) mem[add2[5:0]] <= dataIn2;
      dataOut1 <= mem[add1[5:0]];
      dataOut2 <= mem[add2[5:0]];
   end

   // Reference machine: one instruction retires every fourth cycle after start.
   logic          m_run = 1'b0, m_halt = 1'b0;
   int            m_phase = 0;
   logic [AW-1:0] m_pc = '0;
   logic [31:0]   m_cnt = '0;
   logic [WS-1:0] m_mem [MD];
   logic [WS-1:0] m_iw, m_diff;
   logic [AW-1:0] m_a, m_b, m_c, m_npc;
   logic          m_leq;

   assign m_iw   = m_mem[m_pc[5:0]];
   assign m_a    = m_iw[47:32];
   assign m_b    = m_iw[31:16];
   assign m_c    = m_iw[15:0];
   assign m_diff = m_mem[m_b[5:0]] - m_mem[m_a[5:0]];
   assign m_leq  = m_diff[WS-1] || (m_diff == 0);
   assign m_npc  = m_leq ? m_c : m_pc + 16'd1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_run <= 1'b0; m_halt <= 1'b0; m_phase <= 0; m_pc <= '0; m_cnt <= '0;
      end else begin
         if (ld_en) m_mem[ld_addr] <= ld_data;
         if (!m_run) begin
            if (start) begin
               m_run <= 1'b1; m_halt <= 1'b0; m_phase <= 0; m_pc <= AW'(SPC); m_cnt <= '0;
            end
         end else if (m_phase < 3) begin
            m_phase <= m_phase + 1;
         end else begin
            m_mem[m_b[5:0]] <= m_diff;
            m_cnt   <= m_cnt + 32'd1;
            m_pc    <= m_npc;
            m_phase <= 0;
            if (m_leq && m_c == m_pc) begin
               m_run <= 1'b0; m_halt <= 1'b1;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [WS-1:0] act, input logic [WS-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic monitor();
      logic [WS-1:0] e_add1, e_add2;
      logic          e_w2;
      forever begin
         @(negedge clk);
         e_add1 = '0;
         e_add2 = '0;
         e_w2   = 1'b0;
         if (m_run) begin
            if (m_phase == 0) e_add1 = WS'(m_pc);
            if (m_phase == 2) e_add1 = WS'(m_a);
            if (m_phase >= 2) e_add2 = WS'(m_b);
            e_w2 = (m_phase == 3);
         end
         chk("busy", WS'(busy), WS'(m_run));
         chk("halted", WS'(halted), WS'(m_halt));
         chk("pc", WS'(pc), WS'(m_pc));
         chk("instr_count", WS'(instr_count), WS'(m_cnt));
         chk("add1", add1, e_add1);
         chk("add2", add2, e_add2);
         chk("write2", WS'(write2), WS'(e_w2));
         chk("write1", WS'(write1), '0);
         chk("dataIn1", dataIn1, '0);
         if (e_w2) chk("dataIn2", dataIn2, m_diff);
      end
   endtask

   function automatic logic [WS-1:0] ins(input int a, input int b, input int c);
      return {16'h0, a[15:0], b[15:0], c[15:0]};
   endfunction

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic load(input int a, input logic [WS-1:0] d);
      ld_en = 1'b1; ld_addr = a[5:0]; ld_data = d;
      cyc(1);
      ld_en = 1'b0;
   endtask

   task automatic pulse_start();
      cyc(1);
      start = 1'b1;
      cyc(1);
      start = 1'b0;
   endtask

   task automatic wait_halt(input int max);
      for (int i = 0; i < max && !halted; i++) cyc(1);
      chk("halt_reached", WS'(halted), 64'd1);
   endtask

   initial begin
      fork
         monitor();
      join_none
      #1 rst_n = 1'b0;
      #1;
      chk("rst_busy", WS'(busy), 64'd0);
      chk("rst_halted", WS'(halted), 64'd0);
      chk("rst_pc", WS'(pc), 64'd0);
      chk("rst_count", WS'(instr_count), 64'd0);
      chk("rst_add1", add1, 64'd0);
      chk("rst_add2", add2, 64'd0);
      chk("rst_write2", WS'(write2), 64'd0);
      chk("rst_dataIn2", dataIn2, 64'd0);
      cyc(1);
      rst_n = 1'b1;
      for (int i = 0; i < MD; i++) load(i, '0);

      // reset asserted while fetching
      load(10, ins(3, 4, 12)); load(3, 3); load(4, 4); load(11, ins(0, 0, 11));
      pulse_start();
      chk("fetch_busy", WS'(busy), 64'd1);
      chk("fetch_add1", add1, 64'd10);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", WS'(busy), 64'd0);
      chk("midrst_halted", WS'(halted), 64'd0);
      chk("midrst_write2", WS'(write2), 64'd0);
      chk("midrst_add1", add1, 64'd0);
      chk("midrst_pc", WS'(pc), 64'd0);
      cyc(1);
      rst_n = 1'b1;

      // single non-branching instruction
      pulse_start();
      cyc(3);
      chk("single_write2", WS'(write2), 64'd1);
      chk("single_add2", add2, 64'd4);
      chk("single_dataIn2", dataIn2, 64'd1);
      cyc(1);
      chk("single_pc", WS'(pc), 64'd11);
      chk("single_count", WS'(instr_count), 64'd1);
      wait_halt(20);
      chk("single_mem4", mem[4], 64'd1);
      chk("single_count_end", WS'(instr_count), 64'd2);

      // negative result takes the branch
      load(3, 5); load(4, 2); load(12, ins(0, 0, 12));
      pulse_start();
      cyc(3);
      chk("branch_dataIn2", dataIn2, 64'hFFFF_FFFF_FFFF_FFFD);
      chk("branch_add2", add2, 64'd4);
      cyc(1);
      chk("branch_pc", WS'(pc), 64'd12);
      wait_halt(20);
      chk("branch_mem4", mem[4], 64'hFFFF_FFFF_FFFF_FFFD);
      chk("branch_count", WS'(instr_count), 64'd2);

      // A==B self-loop halts after one instruction, then restarts cleanly
      load(10, ins(0, 0, 10)); load(0, 7);
      pulse_start();
      cyc(4);
      chk("halt_halted", WS'(halted), 64'd1);
      chk("halt_count", WS'(instr_count), 64'd1);
      chk("halt_pc", WS'(pc), 64'd10);
      chk("halt_mem0", mem[0], 64'd0);
      pulse_start();
      chk("restart_pc", WS'(pc), 64'd10);
      chk("restart_count", WS'(instr_count), 64'd0);
      chk("restart_halted", WS'(halted), 64'd0);
      wait_halt(20);

      // reset during the write-back cycle
      load(10, ins(3, 4, 12)); load(3, 3); load(4, 9);
      pulse_start();
      cyc(3);
      chk("exec_write2", WS'(write2), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("exec_rst_write2", WS'(write2), 64'd0);
      chk("exec_rst_add2", add2, 64'd0);
      chk("exec_rst_dataIn2", dataIn2, 64'd0);
      cyc(1);
      rst_n = 1'b1;

      // count mem[5] down from 3 to 0 and self-loop
      load(5, 3); load(6, 1); load(7, 0);
      load(10, ins(6, 5, 13)); load(11, ins(7, 7, 10)); load(13, ins(7, 7, 13));
      pulse_start();
      wait_halt(200);
      chk("loop_mem5", mem[5], 64'd0);
      chk("loop_count", WS'(instr_count), 64'd6);
      chk("loop_pc", WS'(pc), 64'd13);

      // start pulses while running must not disturb the run
      load(5, 3);
      pulse_start();
      for (int k = 0; k < 5; k++) begin
         cyc(k + 1);
         start = 1'b1;
         cyc(1);
         start = 1'b0;
      end
      wait_halt(200);
      chk("busystart_mem5", mem[5], 64'd0);
      chk("busystart_count", WS'(instr_count), 64'd6);

      cyc(2);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
